// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the encryption controller slice.
// Contents: round count NR, round constants RCON[1:10], FSM state encoding,
// and GF(2^8) helpers (xtime, gf_mul, sbox) used by key_expand and round.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    // Round constants, indexed by round number 1..10.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Controller FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        if (rnd inside {[4'd1:4'd10]}) begin
            return RCON[rnd];
        end
        return 8'h00;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as the affine transform of the multiplicative inverse.
    // The inverse is a^254 (0 maps to 0), built by square-and-multiply since
    // 254 = 2 + 4 + ... + 128.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_expand.sv
// Combinational AES-128 key schedule step: derives round key `rnd` from the
// previous round key.
// Ports: rk  [127:0] previous round key (bit 127 = byte 0)
//        rnd [3:0]   round number 1..10 (selects RCON)
//        nk  [127:0] next round key
module key_expand
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [3:0]   rnd,
    output logic [127:0] nk
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    // RotWord, then SubWord, then RCON into the leading byte.
    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]) ^ rcon(rnd), sbox(rot[23:16]),
                   sbox(rot[15:8]), sbox(rot[7:0])};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign nk = {n0, n1, n2, n3};

endmodule

// File: rtl/round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when rc is the final round), AddRoundKey.
// Ports: rc  [3:0]   round number 1..10
//        ctx [127:0] state in (bit 127 = byte 0, column-major)
//        key [127:0] round key
//        ret [127:0] state out
module round
    import aes_pkg::*;
(
    input  logic [3:0]   rc,
    input  logic [127:0] ctx,
    input  logic [127:0] key,
    output logic [127:0] ret
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(ctx[127-8*i -: 8]);
        end
        // Byte index is row + 4*col; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (rc == NR) begin
                mc[4*c]   = sr[4*c];
                mc[4*c+1] = sr[4*c+1];
                mc[4*c+2] = sr[4*c+2];
                mc[4*c+3] = sr[4*c+3];
            end else begin
                mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                          ^ sr[4*c+2] ^ sr[4*c+3];
                mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                          ^ sr[4*c+2] ^ sr[4*c+3];
                mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                          ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
                mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2]
                          ^ xtime(sr[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ret[127-8*i -: 8] = mc[i] ^ key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller: one shared round datapath, round
// keys expanded on the fly, one round per cycle, 12 cycles per block.
// Ports: clk, rst (sync, active-high)
//        start, key_in[127:0], pt_in[127:0]  request and operands
//        ready   high in IDLE only
//        done    one-cycle pulse when ct_out is updated
//        ct_out  [127:0] ciphertext, held until the next completion
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1 (and rst=0); key_in/pt_in are sampled on that edge only. start is
// ignored whenever ready=0; nothing is queued.
module aes_enc_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [127:0] pt_in,
    output logic         ready,
    output logic         done,
    output logic [127:0] ct_out
);

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   cnt;
    logic [3:0]   rnd;
    logic [127:0] nk;
    logic [127:0] ret;

    // Outside RUN, cnt can hold 0 (after reset) or 10; present a legal round
    // number to the datapath so it only ever sees 1..10.
    assign rnd = (state == S_RUN) ? cnt : 4'd1;

    key_expand u_key_expand (
        .rk  (rk),
        .rnd (rnd),
        .nk  (nk)
    );

    round u_round (
        .rc  (rnd),
        .ctx (st),
        .key (nk),
        .ret (ret)
    );

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            st     <= '0;
            rk     <= '0;
            cnt    <= 4'd0;
            ct_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        st    <= pt_in ^ key_in;
                        rk    <= key_in;
                        cnt   <= 4'd1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    st <= ret;
                    rk <= nk;
                    if (cnt == NR) begin
                        ct_out <= ret;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl: known-answer vectors from a table plus
// hand-written back-to-back, start-during-RUN, reset and hold sequences.
// Inputs are driven and outputs sampled on the falling edge.
module tb_aes_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] pt_in;
    logic         ready;
    logic         done;
    logic [127:0] ct_out;

    always #5 clk = ~clk;

    aes_enc_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .key_in (key_in),
        .pt_in  (pt_in),
        .ready  (ready),
        .done   (done),
        .ct_out (ct_out)
    );

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] rk10;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: called on each observed done pulse.
    task automatic sb_compare(input string name);
        logic [127:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s unexpected done, ct_out=%h required=no done", name, ct_out);
        end else begin
            exp = exp_q.pop_front();
            check(name, ct_out, exp);
        end
    endtask

    // Entered at a falling edge with ready expected high; returns at the
    // falling edge of cycle T+1 with start dropped.
    task automatic accept(input logic [127:0] k, input logic [127:0] p,
                          input logic [127:0] ct);
        start  = 1'b1;
        key_in = k;
        pt_in  = p;
        check("ready_before_accept", {127'd0, ready}, 128'd1);
        exp_q.push_back(ct);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges from T+1 until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout actual=no done required=done within 40 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        int           first_ready;
        int           done1;
        int           done2;
        int           done_cnt;
        int           bad;
        logic [127:0] held;

        vecs[0] = '{KEY_B, PT_B, CT_B, RK_B};
        vecs[1] = '{KEY_C, PT_C, CT_C, RK_C};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        // Reset
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        pt_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {127'd0, ready}, 128'd1);
        check("reset_done", {127'd0, done}, 128'd0);
        check("reset_ct_out", ct_out, 128'd0);
        check("reset_cnt", {124'd0, dut.cnt}, 128'd0);
        check("reset_st", dut.st, 128'd0);
        check("reset_rk", dut.rk, 128'd0);

        // Known-answer table
        for (int v = 0; v < 3; v++) begin
            accept(vecs[v].key, vecs[v].pt, vecs[v].ct);
            key_in = ~vecs[v].key;
            pt_in  = ~vecs[v].pt;
            wait_done(lat);
            check($sformatf("vec%0d_latency", v), lat, 128'd11);
            if (done) sb_compare($sformatf("vec%0d_ct", v));
            check($sformatf("vec%0d_rk10", v), dut.rk, vecs[v].rk10);
            @(negedge clk);
            check($sformatf("vec%0d_ready_after", v), {127'd0, ready}, 128'd1);
            check($sformatf("vec%0d_done_pulse", v), {127'd0, done}, 128'd0);
        end

        // Back-to-back with start held high
        start  = 1'b1;
        key_in = KEY_B;
        pt_in  = PT_B;
        exp_q.push_back(CT_B);
        @(posedge clk);
        @(negedge clk);
        key_in = KEY_C;
        pt_in  = PT_C;
        first_ready = 0;
        done1 = 0;
        done2 = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done) begin
                sb_compare("b2b_ct");
                if (done1 == 0) done1 = cyc;
                else if (done2 == 0) done2 = cyc;
            end
            if (ready && first_ready == 0) begin
                first_ready = cyc;
                exp_q.push_back(CT_C);
            end
            if (cyc == 13) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_first_done", done1, 128'd11);
        check("b2b_second_accept", first_ready, 128'd12);
        check("b2b_second_done", done2, 128'd23);

        // start and input changes during RUN
        accept(KEY_B, PT_B, CT_B);
        bad = 0;
        done_cnt = 0;
        done1 = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc <= 11 && ready) bad++;
            if (done) begin
                done_cnt++;
                done1 = cyc;
                sb_compare("run_start_ct");
            end
            if (cyc == 5) begin
                start  = 1'b1;
                key_in = 128'hdeadbeef_00000000_cafef00d_12345678;
                pt_in  = 128'hffffffff_00000000_ffffffff_00000000;
            end
            if (cyc == 6) start = 1'b0;
            @(negedge clk);
        end
        check("run_start_ready_low", bad, 128'd0);
        check("run_start_done_at", done1, 128'd11);
        check("run_start_done_count", done_cnt, 128'd1);
        check("run_start_no_extra_accept", {127'd0, ready}, 128'd1);

        // Reset mid-operation
        accept(KEY_C, PT_C, CT_C);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 7) begin
                rst = 1'b0;
                check("midrst_ready", {127'd0, ready}, 128'd1);
                check("midrst_ct_out", ct_out, 128'd0);
                check("midrst_cnt", {124'd0, dut.cnt}, 128'd0);
                exp_q.delete();
            end
            if (cyc >= 7 && done) done_cnt++;
            if (cyc == 6) rst = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_done", done_cnt, 128'd0);

        // rst and start in the same cycle: start must not be accepted
        rst    = 1'b1;
        start  = 1'b1;
        key_in = KEY_B;
        pt_in  = PT_B;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_ready", {127'd0, ready}, 128'd1);
        done_cnt = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("rst_start_no_done", done_cnt, 128'd0);

        // Fresh run after reset
        accept(KEY_C, PT_C, CT_C);
        wait_done(lat);
        check("post_rst_latency", lat, 128'd11);
        if (done) sb_compare("post_rst_ct");

        // ct_out hold while idle
        held = CT_C;
        bad = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (ct_out !== held || done !== 1'b0 || ready !== 1'b1) bad++;
        end
        check("hold_ct_out", ct_out, CT_C);
        check("hold_violations", bad, 128'd0);
        check("sb_queue_drained", exp_q.size(), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
